mat_switch_arbiter: RTL and testbench

MAT_SWITCH_ARBITER -- requirements
Module: mat_switch_arbiter

---
 rtl/mat_switch_arbiter_if.sv | 28 ++
 rtl/mat_switch_arbiter.sv | 100 ++++++++++
 tb/tb_mat_switch_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_switch_arbiter_if.sv
// Core-side bus of the mailbox switch: send offers, receive requests, delivered data and the delivery counter.
// Each vector lane carries the raw IEEE-754 single-precision (shortreal) bit pattern.
interface mat_switch_arbiter_if #(
  parameter int SWITCH_WIDTH     = 16,
  parameter int SWITCH_CORE_SIZE = 4
);
  localparam int CORE_ADDR = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1;

  logic [SWITCH_CORE_SIZE-1:0]                         send_ready;
  logic [SWITCH_CORE_SIZE-1:0][CORE_ADDR-1:0]          send_core_idx;
  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0] send_data;
  logic [SWITCH_CORE_SIZE-1:0]                         send_ok;
  logic [SWITCH_CORE_SIZE-1:0]                         recv_request;
  logic [SWITCH_CORE_SIZE-1:0][CORE_ADDR-1:0]          recv_core_idx;
  logic [SWITCH_CORE_SIZE-1:0]                         recv_ready;
  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0] recv_data;
  logic [31:0]                                         xfer_count;

  modport master (
    output send_ready, send_core_idx, send_data, recv_request, recv_core_idx,
    input  send_ok, recv_ready, recv_data, xfer_count
  );

  modport slave (
    input  send_ready, send_core_idx, send_data, recv_request, recv_core_idx,
    output send_ok, recv_ready, recv_data, xfer_count
  );
endinterface

// File: rtl/mat_switch_arbiter.sv
// Per-destination single-entry mailbox switch with round-robin sender arbitration.
// Define MAT_SWITCH_BYPASS_EN to forward a grant straight to a waiting receiver when its mailbox is empty.
module mat_switch_arbiter #(
  parameter int SWITCH_WIDTH     = 16,
  parameter int SWITCH_CORE_SIZE = 4
) (
  input logic                clock,
  input logic                reset,
  mat_switch_arbiter_if.slave bus
);
  localparam int unsigned N         = SWITCH_CORE_SIZE;
  localparam int          CORE_ADDR = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1;

  typedef logic [SWITCH_WIDTH-1:0][31:0] vec_t;
  typedef logic [CORE_ADDR-1:0]          idx_t;

  logic [N-1:0] mb_full;
  idx_t         mb_src  [N];
  vec_t         mb_data [N];
  idx_t         rr      [N];
  vec_t         last_q  [N];
  logic [31:0]  xfer_q;

  logic [N-1:0] drain, gnt_vld, bypass, deliver, send_ok;
  idx_t         gnt_src [N];
  vec_t         rdata   [N];

  always_comb begin
    int unsigned s;
    s       = 0;
    send_ok = '0;
    for (int unsigned d = 0; d < N; d++) begin
      gnt_vld[d] = 1'b0;
      gnt_src[d] = '0;
      bypass[d]  = 1'b0;
      drain[d]   = !reset && mb_full[d] && bus.recv_request[d] &&
                   (bus.recv_core_idx[d] == mb_src[d]);
      // first candidate at or after rr[d], wrapping at N (N need not be a power of two)
      for (int unsigned k = 0; k < N; k++) begin
        s = 32'(rr[d]) + k;
        if (s >= N) s = s - N;
        if (!gnt_vld[d] && bus.send_ready[idx_t'(s)] &&
            (bus.send_core_idx[idx_t'(s)] == idx_t'(d))) begin
          gnt_vld[d] = 1'b1;
          gnt_src[d] = idx_t'(s);
        end
      end
      if (reset || (mb_full[d] && !drain[d])) gnt_vld[d] = 1'b0;
`ifdef MAT_SWITCH_BYPASS_EN
      bypass[d] = gnt_vld[d] && !mb_full[d] && bus.recv_request[d] &&
                  (bus.recv_core_idx[d] == gnt_src[d]);
`endif
      deliver[d] = drain[d] || bypass[d];
      if (drain[d])
        rdata[d] = mb_data[d];
`ifdef MAT_SWITCH_BYPASS_EN
      else if (bypass[d])
        rdata[d] = bus.send_data[gnt_src[d]];
`endif
      else
        rdata[d] = last_q[d];
    end
    for (int unsigned d = 0; d < N; d++)
      if (gnt_vld[d]) send_ok[gnt_src[d]] = 1'b1;
  end

  always_comb begin
    bus.send_ok    = send_ok;
    bus.recv_ready = deliver;
    bus.xfer_count = xfer_q;
    for (int unsigned d = 0; d < N; d++)
      bus.recv_data[d] = rdata[d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mb_full <= '0;
      xfer_q  <= '0;
      for (int unsigned d = 0; d < N; d++) begin
        rr[d]     <= '0;
        last_q[d] <= '0;
      end
    end else begin
      xfer_q <= xfer_q + 32'($countones(deliver));
      for (int unsigned d = 0; d < N; d++) begin
        last_q[d] <= rdata[d];
        // a refill in the drain cycle keeps the mailbox full, sustaining one vector per cycle
        if (gnt_vld[d] && !bypass[d]) begin
          mb_full[d] <= 1'b1;
          mb_src[d]  <= gnt_src[d];
          mb_data[d] <= bus.send_data[gnt_src[d]];
        end else if (drain[d]) begin
          mb_full[d] <= 1'b0;
        end
        if (gnt_vld[d])
          rr[d] <= (32'(gnt_src[d]) == N - 1) ? '0 : gnt_src[d] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mat_switch_arbiter.sv
// Directed scenarios plus randomized traffic for mat_switch_arbiter, checked against a per-destination mailbox model.
module tb_mat_switch_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CA = 2;

  typedef logic [W*32-1:0] vec_t;
  typedef logic [CA-1:0]   idx_t;

  logic clock;
  logic reset;

  mat_switch_arbiter_if #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) bus ();

  mat_switch_arbiter #(.SWITCH_WIDTH(W), .SWITCH_CORE_SIZE(N)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: one mailbox and one round-robin pointer per destination
  bit          m_full [N];
  int          m_src  [N];
  vec_t        m_data [N];
  int          m_rr   [N];
  vec_t        m_last [N];
  logic [31:0] m_cnt;

  logic [N-1:0] o_ok, o_rdy;
  logic [31:0]  o_cnt;
  vec_t         o_dat [N];

  int grant_seq [4] = '{1, 2, 8, 1};
  int src_seq   [4] = '{0, 1, 3, 0};

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < W; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle();
    bus.send_ready    = '0;
    bus.send_core_idx = '0;
    bus.send_data     = '0;
    bus.recv_request  = '0;
    bus.recv_core_idx = '0;
  endtask

  task automatic offer(int s, int d, vec_t v);
    bus.send_ready[s]    = 1'b1;
    bus.send_core_idx[s] = idx_t'(d);
    bus.send_data[s]     = v;
  endtask

  task automatic request(int c, int src);
    bus.recv_request[c]  = 1'b1;
    bus.recv_core_idx[c] = idx_t'(src);
  endtask

  // one clock cycle: compare DUT against the model before the edge, then advance the model
  task automatic step();
    logic [N-1:0] e_ok, e_rdy;
    vec_t e_dat [N];
    vec_t gdat  [N];
    int   win   [N];
    bit   drn   [N];
    bit   byp   [N];
    int   s;
    #1;
    e_ok  = '0;
    e_rdy = '0;
    for (int d = 0; d < N; d++) begin
      drn[d] = !reset && m_full[d] && bus.recv_request[d] && (int'(bus.recv_core_idx[d]) == m_src[d]);
      win[d] = -1;
      for (int k = 0; k < N; k++) begin
        s = (m_rr[d] + k) % N;
        if (win[d] < 0 && bus.send_ready[s] && int'(bus.send_core_idx[s]) == d) win[d] = s;
      end
      if (reset || (m_full[d] && !drn[d])) win[d] = -1;
      byp[d] = 1'b0;
`ifdef MAT_SWITCH_BYPASS_EN
      byp[d] = win[d] >= 0 && !m_full[d] && bus.recv_request[d] && int'(bus.recv_core_idx[d]) == win[d];
`endif
      gdat[d] = (win[d] >= 0) ? vec_t'(bus.send_data[win[d]]) : '0;
      if (win[d] >= 0) e_ok[win[d]] = 1'b1;
      e_rdy[d] = drn[d] || byp[d];
      e_dat[d] = drn[d] ? m_data[d] : (byp[d] ? gdat[d] : m_last[d]);
    end
    o_ok  = bus.send_ok;
    o_rdy = bus.recv_ready;
    o_cnt = bus.xfer_count;
    chk("send_ok", 512'(o_ok), 512'(e_ok));
    chk("recv_ready", 512'(o_rdy), 512'(e_rdy));
    chk("xfer_count", 512'(o_cnt), 512'(m_cnt));
    for (int c = 0; c < N; c++) begin
      o_dat[c] = bus.recv_data[c];
      chk($sformatf("recv_data[%0d]", c), o_dat[c], e_dat[c]);
    end
    @(posedge clock);
    if (reset) begin
      m_cnt = '0;
      for (int d = 0; d < N; d++) begin
        m_full[d] = 1'b0;
        m_rr[d]   = 0;
        m_last[d] = '0;
      end
    end else begin
      m_cnt = m_cnt + 32'($countones(e_rdy));
      for (int d = 0; d < N; d++) begin
        if (e_rdy[d]) m_last[d] = e_dat[d];
        if (win[d] >= 0 && !byp[d]) begin
          m_full[d] = 1'b1;
          m_src[d]  = win[d];
          m_data[d] = gdat[d];
        end else if (drn[d]) begin
          m_full[d] = 1'b0;
        end
        if (win[d] >= 0) m_rr[d] = (win[d] + 1) % N;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   src;
    reset = 1'b1;
    idle();
    @(posedge clock);
    @(negedge clock);
    m_cnt = '0;
    for (int d = 0; d < N; d++) begin
      m_full[d] = 1'b0;
      m_src[d]  = 0;
      m_data[d] = '0;
      m_rr[d]   = 0;
      m_last[d] = '0;
    end

    do_reset();
    chk("reset_xfer_count", 512'(o_cnt), 512'(0));
    chk("reset_recv_data0", o_dat[0], 512'(0));

    // single transfer core1 -> core2, lane0 = 1.5
    idle();
    v = '0;
    v[31:0] = 32'h3FC0_0000;
    offer(1, 2, v);
    step();
    chk("s1_send_ok", 512'(o_ok), 512'(4'b0010));
    idle();
    request(2, 1);
    step();
    chk("s1_recv_ready", 512'(o_rdy), 512'(4'b0100));
    chk("s1_lane0", 512'(o_dat[2][31:0]), 512'(32'h3FC0_0000));
    idle();
    step();
    chk("s1_xfer_count", 512'(o_cnt), 512'(1));
    chk("s1_held_lane0", 512'(o_dat[2][31:0]), 512'(32'h3FC0_0000));

    // three senders contend for core2, receiver follows grant order
    do_reset();
    for (int t = 0; t < 5; t++) begin
      idle();
      offer(0, 2, rvec());
      offer(1, 2, rvec());
      offer(3, 2, rvec());
      if (t > 0) request(2, src_seq[t-1]);
      step();
      if (t < 4) chk($sformatf("s2_grant_t%0d", t), 512'(o_ok), 512'(grant_seq[t]));
      if (t > 0) chk($sformatf("s2_deliver_t%0d", t), 512'(o_rdy), 512'(4'b0100));
    end

    // source mismatch holds mailbox and blocks new grants for that destination
    do_reset();
    idle();
    offer(0, 2, rvec());
    step();
    chk("s3_first_grant", 512'(o_ok), 512'(4'b0001));
    v = rvec();
    for (int t = 0; t < 2; t++) begin
      idle();
      offer(3, 2, v);
      request(2, 3);
      step();
      chk("s3_blocked_rdy", 512'(o_rdy), 512'(0));
      chk("s3_blocked_ok", 512'(o_ok), 512'(0));
    end
    idle();
    offer(3, 2, v);
    request(2, 0);
    step();
    chk("s3_drain_rdy", 512'(o_rdy), 512'(4'b0100));
    chk("s3_refill_ok", 512'(o_ok), 512'(4'b1000));
    idle();
    request(2, 3);
    step();
    chk("s3_src3_data", o_dat[2], v);

    // reset right after an acknowledged send discards it and restarts arbitration
    do_reset();
    idle();
    offer(1, 2, rvec());
    step();
    chk("s4_send_ok", 512'(o_ok), 512'(4'b0010));
    reset = 1'b1;
    idle();
    request(2, 1);
    offer(0, 2, rvec());
    step();
    chk("s4_rst_ok", 512'(o_ok), 512'(0));
    chk("s4_rst_rdy", 512'(o_rdy), 512'(0));
    reset = 1'b0;
    idle();
    request(2, 1);
    step();
    chk("s4_no_deliver", 512'(o_rdy), 512'(0));
    chk("s4_count", 512'(o_cnt), 512'(0));
    idle();
    offer(0, 2, rvec());
    offer(1, 2, rvec());
    offer(3, 2, rvec());
    step();
    chk("s4_rr_restart", 512'(o_ok), 512'(4'b0001));

    // coincident send and matching request on an empty mailbox
    do_reset();
    idle();
    v = rvec();
    offer(3, 0, v);
    request(0, 3);
    step();
    chk("s5_send_ok", 512'(o_ok), 512'(4'b1000));
`ifdef MAT_SWITCH_BYPASS_EN
    chk("s5_bypass_rdy", 512'(o_rdy), 512'(4'b0001));
    chk("s5_bypass_data", o_dat[0], v);
`else
    chk("s5_same_cycle_rdy", 512'(o_rdy), 512'(0));
    idle();
    request(0, 3);
    step();
    chk("s5_next_cycle_rdy", 512'(o_rdy), 512'(4'b0001));
    chk("s5_next_cycle_data", o_dat[0], v);
`endif

    // counter wrap with two deliveries in one cycle
    do_reset();
    idle();
    offer(0, 0, rvec());
    offer(1, 1, rvec());
    step();
    chk("s6_send_ok", 512'(o_ok), 512'(4'b0011));
    idle();
    request(0, 0);
    request(1, 1);
    force dut.xfer_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_q;
    step();
    chk("s6_two_deliveries", 512'(o_rdy), 512'(4'b0011));
    idle();
    step();
    chk("s6_wrap", 512'(o_cnt), 512'(32'h0000_0001));

    // randomized traffic with occasional reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 1) == 1) offer(s, $urandom_range(0, N-1), rvec());
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 2) != 0) begin
          src = ($urandom_range(0, 1) == 1 && m_full[c]) ? m_src[c] : $urandom_range(0, N-1);
          request(c, src);
        end
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
